// File: rtl/hub75_driver.sv
// hub75_driver: double-buffered HUB75 scanner; column pairs written via col_num/columns/data_valid (hub75_ready), panel driven on hub75_r/g/b/addr/clk/lat/oe_n with hub75_last per frame
module hub75_driver #(
  parameter int SCAN_RATE = 32,
  parameter int NUM_ROWS  = 64,
  parameter int RGB_RES   = 9,
  parameter int BASE_TIME = 32
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [$clog2(SCAN_RATE)-1:0]          col_num,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
  input  logic                                  data_valid,
  output logic                                  hub75_ready,
  output logic                                  hub75_last,
  output logic [1:0]                            hub75_r,
  output logic [1:0]                            hub75_g,
  output logic [1:0]                            hub75_b,
  output logic [$clog2(SCAN_RATE)-1:0]          hub75_addr,
  output logic                                  hub75_clk,
  output logic                                  hub75_lat,
  output logic                                  hub75_oe_n
);
  localparam int CH = RGB_RES / 3;
  localparam int LW = $clog2(SCAN_RATE);
  localparam int PW = CH > 1 ? $clog2(CH) : 1;
  localparam int CW = $clog2((BASE_TIME << (CH - 1)) + 4 * SCAN_RATE);
  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY, SWAP} state_t;
  state_t st, n_st;
  logic [CW-1:0] cnt, n_cnt;
  logic [LW-1:0] line, n_line;
  logic [PW-1:0] plane, n_plane;
  logic front, n_front;
  logic shift_end, disp_end, plane_end, frame_end;
  logic [RGB_RES-1:0] up, lo;
  logic [CH-1:0] ur, ug, ub, lr, lg, lb;
  logic [NUM_ROWS-1:0][RGB_RES-1:0] mem [2][2*SCAN_RATE];
  always_comb begin
    shift_end = cnt == CW'(4 * SCAN_RATE - 1);
    disp_end  = cnt == (CW'(BASE_TIME) << plane) - CW'(1);
    plane_end = plane == PW'(CH - 1);
    frame_end = plane_end && line == LW'(SCAN_RATE - 1);
    case (st)
      IDLE:    n_st = SHIFT;
      SHIFT:   n_st = shift_end ? BLANK : SHIFT;
      BLANK:   n_st = LATCH;
      LATCH:   n_st = DISPLAY;
      DISPLAY: n_st = disp_end ? (frame_end ? SWAP : SHIFT) : DISPLAY;
      default: n_st = SHIFT;
    endcase
    n_cnt   = n_st == st ? cnt + CW'(1) : '0;
    n_plane = st == DISPLAY && disp_end ? (plane_end ? '0 : plane + PW'(1)) : plane;
    n_line  = st == DISPLAY && disp_end && plane_end ? (frame_end ? '0 : line + LW'(1)) : line;
    n_front = st == SWAP ? ~front : front;
    up = mem[n_front][n_cnt[LW+1:1]][{1'b0, n_line}];
    lo = mem[n_front][n_cnt[LW+1:1]][{1'b1, n_line}];
    {ur, ug, ub} = up;
    {lr, lg, lb} = lo;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st          <= IDLE;
      cnt         <= '0;
      line        <= '0;
      plane       <= '0;
      front       <= 1'b0;
      hub75_ready <= 1'b0;
      hub75_last  <= 1'b0;
      hub75_r     <= '0;
      hub75_g     <= '0;
      hub75_b     <= '0;
      hub75_addr  <= '0;
      hub75_clk   <= 1'b0;
      hub75_lat   <= 1'b0;
      hub75_oe_n  <= 1'b1;
    end else begin
      st          <= n_st;
      cnt         <= n_cnt;
      line        <= n_line;
      plane       <= n_plane;
      front       <= n_front;
      hub75_ready <= n_st != SWAP;
      hub75_last  <= n_st == SWAP;
      hub75_r     <= n_st == SHIFT ? {lr[n_plane], ur[n_plane]} : 2'b00;
      hub75_g     <= n_st == SHIFT ? {lg[n_plane], ug[n_plane]} : 2'b00;
      hub75_b     <= n_st == SHIFT ? {lb[n_plane], ub[n_plane]} : 2'b00;
      hub75_addr  <= n_st == BLANK ? n_line : hub75_addr;
      hub75_clk   <= n_st == SHIFT && n_cnt[0];
      hub75_lat   <= n_st == LATCH;
      hub75_oe_n  <= n_st != DISPLAY;
    end
  end
  always_ff @(posedge clk_in) begin
    if (data_valid && hub75_ready) begin
      mem[~front][{1'b0, col_num}] <= columns[0];
      mem[~front][{1'b1, col_num}] <= columns[1];
    end
  end
endmodule

// File: tb/tb_hub75_driver.sv
// tb_hub75_driver: randomized scoreboard bench for hub75_driver against a frame-schedule reference model
module tb_hub75_driver;
  localparam int S = 32, CH = 3, BT = 32;
  localparam int SEG0 = 4 * S + 2;
  localparam int LINE_LEN = CH * SEG0 + BT * ((1 << CH) - 1);
  localparam int P = S * LINE_LEN + 1;
  localparam int K_RST = 0, K_IDLE = 1, K_SHIFT = 2, K_BLANK = 3, K_LATCH = 4, K_DISP = 5, K_SWAP = 6;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [4:0] col_num = '0;
  logic [1:0][63:0][8:0] columns = '0;
  logic data_valid = 1'b0;
  logic hub75_ready, hub75_last, hub75_clk, hub75_lat, hub75_oe_n;
  logic [1:0] hub75_r, hub75_g, hub75_b;
  logic [4:0] hub75_addr;
  typedef struct {logic [15:0] e; bit rk; int x; bit dir; int k;} exp_t;
  exp_t q[$];
  logic [8:0] mb [2][64][64];
  bit kn [2][64];
  bit mf;
  int maddr;
  int tests = 0, fails = 0;
  hub75_driver dut (
    .clk_in(clk_in), .rst_in(rst_in), .col_num(col_num), .columns(columns),
    .data_valid(data_valid), .hub75_ready(hub75_ready), .hub75_last(hub75_last),
    .hub75_r(hub75_r), .hub75_g(hub75_g), .hub75_b(hub75_b), .hub75_addr(hub75_addr),
    .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n)
  );
  always #5 clk_in = ~clk_in;
  function automatic void sched(input int k, output int kind, output int line, output int plane, output int off);
    int j, r;
    line = 0;
    plane = 0;
    off = 0;
    kind = K_IDLE;
    if (k < 0) kind = K_RST;
    if (k <= 0) return;
    j = (k - 1) % P;
    if (j == P - 1) begin
      kind = K_SWAP;
      return;
    end
    line = j / LINE_LEN;
    r = j % LINE_LEN;
    while (r >= SEG0 + (BT << plane)) begin
      r -= SEG0 + (BT << plane);
      plane++;
    end
    kind = r < 4 * S ? K_SHIFT : r == 4 * S ? K_BLANK : r == 4 * S + 1 ? K_LATCH : K_DISP;
    off = kind == K_DISP ? r - 4 * S - 2 : r;
  endfunction
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic rand_cols();
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 64; r++) columns[h][r] = 9'($urandom);
  endtask
  task automatic do_reset(input int n);
    exp_t it;
    rst_in = 1'b1;
    mf = 1'b0;
    maddr = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      it.e = 16'h0001;
      it.rk = 1'b1;
      it.x = -1;
      it.dir = 1'b0;
      it.k = -1;
      q.push_back(it);
      data_valid = 1'($urandom);
      col_num = 5'($urandom);
    end
  endtask
  task automatic run(input int ncyc, input int dir_fr, input bit mid_rst);
    int kind, line, plane, off, fr, jj, x;
    bit rdy;
    logic [8:0] pu, pd;
    exp_t it;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (k == 0) rst_in = 1'b0;
      sched(k, kind, line, plane, off);
      fr = k == 0 ? 0 : (k - 1) / P;
      jj = k == 0 ? -1 : (k - 1) % P;
      if (kind == K_BLANK) maddr = line;
      rdy = kind inside {K_SHIFT, K_BLANK, K_LATCH, K_DISP};
      it.e = {rdy, kind == K_SWAP, 6'b0, 5'(maddr), kind == K_SHIFT && off % 2 == 1, kind == K_LATCH, kind != K_DISP};
      it.rk = 1'b1;
      it.x = -1;
      it.dir = 1'b0;
      it.k = k;
      if (kind == K_SHIFT) begin
        x = off / 2;
        it.x = x;
        it.dir = fr == dir_fr;
        it.rk = kn[mf][x];
        pu = mb[mf][x][line];
        pd = mb[mf][x][line + S];
        it.e[13:8] = {pd[2*CH+plane], pu[2*CH+plane], pd[CH+plane], pu[CH+plane], pd[plane], pu[plane]};
      end
      q.push_back(it);
      if (kind == K_SWAP) begin
        data_valid = 1'b1;
        col_num = 5'd5;
        rand_cols();
      end else if (jj >= 0 && jj < S) begin
        data_valid = 1'b1;
        col_num = 5'(jj);
        rand_cols();
      end else if (dir_fr == 1 && fr == 0 && jj == 100) begin
        data_valid = 1'b1;
        col_num = 5'd3;
        for (int r = 0; r < 64; r++) begin
          columns[0][r] = 9'h1C0;
          columns[1][r] = 9'h000;
        end
      end else begin
        data_valid = $urandom_range(0, 3) == 0;
        col_num = 5'($urandom);
        if (dir_fr == 1 && fr == 0 && jj > 100 && col_num == 5'd3) col_num = 5'd4;
        if (data_valid) rand_cols();
      end
      if (data_valid && rdy)
        for (int h = 0; h < 2; h++) begin
          kn[!mf][h*S+int'(col_num)] = 1'b1;
          for (int r = 0; r < 64; r++) mb[!mf][h*S+int'(col_num)][r] = columns[h][r];
        end
      if (kind == K_SWAP) mf = !mf;
      if (mid_rst && kind == K_DISP && line == 17 && plane == 1 && off == 5) begin
        rst_in = 1'b1;
        break;
      end
    end
  endtask
  exp_t mit;
  logic [15:0] act, msk;
  int cyc = 0, prev_last = -1, run_len = 0, run_pl = 0, lats = 0;
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (q.size() > 0) begin
        mit = q.pop_front();
        act = {hub75_ready, hub75_last, hub75_r, hub75_g, hub75_b, hub75_addr, hub75_clk, hub75_lat, hub75_oe_n};
        msk = mit.rk ? 16'hFFFF : 16'hC0FF;
        if (fails < 100) begin
          tests++;
          if ((act & msk) !== (mit.e & msk)) begin
            fails++;
            $display("FAIL cycle k=%0d: outputs %h, required %h", mit.k, act & msk, mit.e & msk);
          end
        end
        if (mit.dir && (mit.x == 3 || mit.x == 35)) begin
          tests++;
          if ({hub75_r, hub75_g, hub75_b} !== (mit.x == 3 ? 6'b110000 : 6'b000000)) begin
            fails++;
            $display("FAIL pixel x=%0d k=%0d: rgb %b, required %b", mit.x, mit.k, {hub75_r, hub75_g, hub75_b},
                     mit.x == 3 ? 6'b110000 : 6'b000000);
          end
        end
        if (rst_in) begin
          prev_last = -1;
          run_len = 0;
          run_pl = 0;
          lats = 0;
        end else begin
          if (hub75_last === 1'b1) begin
            if (prev_last >= 0) begin
              tests++;
              if (cyc - prev_last != 19649) begin
                fails++;
                $display("FAIL last_spacing: got %0d cycles, required 19649", cyc - prev_last);
              end
            end
            prev_last = cyc;
          end
          if (hub75_oe_n === 1'b0) begin
            if (run_len == 0) begin
              tests++;
              if (lats != 1) begin
                fails++;
                $display("FAIL lat_before_display: got %0d latch cycles, required 1", lats);
              end
              lats = 0;
            end
            run_len++;
          end else begin
            if (run_len > 0) begin
              tests++;
              if (run_len != (BT << run_pl)) begin
                fails++;
                $display("FAIL display_run plane %0d: got %0d cycles, required %0d", run_pl, run_len, BT << run_pl);
              end
              run_pl = (run_pl + 1) % CH;
              run_len = 0;
            end
            if (hub75_lat === 1'b1) lats++;
          end
        end
      end
    end
  end
  initial begin
    do_reset(10);
    run(P, -1, 1'b1);
    do_reset(10);
    run(3 * P + 20, 1, 1'b0);
    tick();
    tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hub75_driver.md
HUB75_DRIVER -- requirements
Module: hub75_driver

Interface
REQ-001 SHALL have parameter SCAN_RATE, default 32: scan lines per panel; also the column count per half-panel.
REQ-002 SHALL have parameter NUM_ROWS, default 64: pixel rows per column, equal to 2*SCAN_RATE.
REQ-003 SHALL have parameter RGB_RES, default 9: bits per pixel packed {R,G,B}, CH=RGB_RES/3 bits per channel; RGB_RES is a multiple of 3.
REQ-004 SHALL have parameter BASE_TIME, default 32: display cycles for bit plane 0.
REQ-005 SHALL have port clk_in, input, 1 bit: single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port col_num, input, $clog2(SCAN_RATE) bits: column index within each half.
REQ-008 SHALL have port columns, input, [1:0][NUM_ROWS-1:0][RGB_RES-1:0]: index h is the column for half h.
REQ-009 SHALL have port data_valid, input, 1 bit: qualifies col_num and columns for one cycle.
REQ-010 SHALL have port hub75_ready, output, 1 bit: a write is accepted this cycle.
REQ-011 SHALL have port hub75_last, output, 1 bit: one-cycle end-of-frame and bank-swap pulse.
REQ-012 SHALL have ports hub75_r/g/b, output, [1:0] each: bit 0 = upper row, bit 1 = lower row.
REQ-013 SHALL have port hub75_addr, output, $clog2(SCAN_RATE) bits: scan-line address.
REQ-014 SHALL have ports hub75_clk, hub75_lat, hub75_oe_n, output, 1 bit each: shift clock, latch, active-low output enable.

Function
REQ-015 SHALL hold two banks, each 2*SCAN_RATE columns x NUM_ROWS pixels; panel column x={h,col_num}; writes go to the back bank, scan reads the front bank.
REQ-016 SHALL, when data_valid && hub75_ready, write columns[0] to back-bank column {0,col_num} and columns[1] to {1,col_num} in the same cycle.
REQ-017 SHALL drop data_valid beats while hub75_ready=0, with no bank change.
REQ-018 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY, SWAP.
REQ-019 SHALL spend exactly 1 cycle in IDLE after reset, then enter SHIFT with line=0 and plane=0.
REQ-020 SHALL in SHIFT emit pixels x=0..2*SCAN_RATE-1, 2 cycles each: cycle A drives data with hub75_clk=0; cycle B holds data with hub75_clk=1.
REQ-021 SHALL drive hub75_r[0] = bit plane of R of row line, and hub75_r[1] = same for row line+SCAN_RATE; G and B likewise; R=pixel[RGB_RES-1 -: CH], B=pixel[CH-1:0].
REQ-022 SHALL absorb the bank read latency internally, with no gap cycles inside SHIFT; SHIFT lasts 4*SCAN_RATE cycles.
REQ-023 SHALL spend 1 cycle in BLANK with hub75_oe_n=1, updating hub75_addr to line only in this state.
REQ-024 SHALL spend 1 cycle in LATCH with hub75_lat=1 and hub75_oe_n=1.
REQ-025 SHALL spend BASE_TIME<<plane cycles in DISPLAY with hub75_oe_n=0; hub75_oe_n=1 in every other state.
REQ-026 SHALL after DISPLAY increment plane (0..CH-1, LSB first); at plane wrap increment line; after line SCAN_RATE-1 / plane CH-1 enter SWAP, otherwise SHIFT.
REQ-027 SHALL in SWAP (1 cycle) assert hub75_last=1 and hub75_ready=0, toggle front/back banks, reset line and plane to 0, then enter SHIFT.
REQ-028 SHALL hold hub75_ready=1 in all states except SWAP and reset; hub75_last=0 outside SWAP.
REQ-029 SHALL hold hub75_lat=0, hub75_clk=0 and RGB=0 outside the states that define them.
REQ-030 SHALL give a frame period of SCAN_RATE*(CH*(4*SCAN_RATE+2)+BASE_TIME*(2^CH-1))+1 cycles; 19649 with default parameters.

Reset
REQ-031 SHALL while rst_in=1 drive hub75_oe_n=1, hub75_lat=0, hub75_clk=0, RGB=0, hub75_addr=0, hub75_ready=0, hub75_last=0, with state IDLE, line=0, plane=0, front bank=0.
REQ-032 SHALL on reset mid-frame abort immediately with no latch pulse, and not clear bank contents.

Verification
REQ-033 SHALL be verified by: reset 10 cycles, release -> all outputs at reset values; hub75_ready=1 in the cycle after IDLE; first SHIFT begins 1 cycle after IDLE.
REQ-034 SHALL be verified by: write col_num=3 with columns[0] all 9'h1C0 and columns[1] all 0, then wait one hub75_last -> in the next frame, pixel x=3 shows hub75_r=2'b11 for planes 0-2 on every line, and pixel x=35 shows RGB=0.
REQ-035 SHALL be verified by: counting DISPLAY hub75_oe_n=0 runs for one line -> 32, 64 and 128 cycles, each preceded by exactly one hub75_lat pulse.
REQ-036 SHALL be verified by: data_valid held during the SWAP cycle -> write dropped; back bank unchanged.
REQ-037 SHALL be verified by: hub75_last pulses over 3 frames -> spacing exactly 19649 cycles, each 1 cycle wide, with hub75_ready=0 in the same cycle.
REQ-038 SHALL be verified by: rst_in asserted during DISPLAY of line 17 -> next cycle hub75_oe_n=1, hub75_addr=0; restart scans from line 0.
